// File: rtl/wb_stepper.sv
// wb_stepper: Wishbone-controlled stepper motor pulse generator.
// Generates STEP/DIR/EN_n for a single driver, tracks signed position,
// and raises a level interrupt when a move completes or is aborted.
module wb_stepper #(
    parameter int unsigned PULSE_W   = 10,
    parameter int unsigned DIR_SETUP = 50
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_we_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    output logic        wb_ack_o,
    output logic        step_o,
    output logic        dir_o,
    output logic        en_n_o,
    output logic        intr
);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_HIGH, S_LOW} state_t;

    localparam logic [31:0] PW        = PULSE_W;
    localparam logic [31:0] SETUP_CNT = DIR_SETUP - 1;
    localparam logic [31:0] HIGH_CNT  = PULSE_W - 1;

    state_t             state;
    logic [31:0]        cnt;
    logic [15:0]        remaining;
    logic [15:0]        steps;
    logic [31:0]        period;
    logic signed [31:0] pos;
    logic               dir;
    logic               enable;
    logic               irq_en;
    logic               done;
    logic               aborted;

    // LOW-phase counter preload: the period is clamped so LOW lasts at least one cycle.
    function automatic logic [31:0] low_cycles(input logic [31:0] p);
        logic [31:0] eff;
        eff = (p < PW + 32'd1) ? PW + 32'd1 : p;
        return eff - PW - 32'd1;
    endfunction

    logic       req;
    logic       wr;
    logic [2:0] idx;
    logic       busy;
    logic       wr_ctrl;
    logic       wr_status;
    logic       abort_req;
    logic       start_req;
    logic       kill;
    logic       start_ok;
    logic       finish;
    logic       done_set;
    logic [31:0] rdata;
    logic       unused;

    assign req       = wb_cyc_i & wb_stb_i & ~wb_ack_o;
    assign wr        = req & wb_we_i;
    assign idx       = wb_adr_i[4:2];
    assign busy      = (state != S_IDLE);
    assign wr_ctrl   = wr && (idx == 3'd0);
    assign wr_status = wr && (idx == 3'd1);
    // Dropping ENABLE during a move is treated the same as an explicit ABORT.
    assign abort_req = wr_ctrl & (wb_dat_i[2] | ~wb_dat_i[3]);
    assign start_req = wr_ctrl & wb_dat_i[0] & wb_dat_i[3] & ~wb_dat_i[2];
    assign kill      = busy & abort_req;
    assign start_ok  = ~busy & start_req;
    assign finish    = (state == S_LOW) && (cnt == 32'd0) && (remaining == 16'd0);
    assign done_set  = (start_ok && (steps == 16'd0)) | kill | finish;

    assign en_n_o = ~enable;
    assign intr   = done & irq_en;
    assign unused = ^{wb_sel_i, wb_adr_i[31:5], wb_adr_i[1:0]};

    // Register read multiplexer.
    always_comb begin
        rdata = '0;
        case (idx)
            3'd0:    rdata = {27'd0, irq_en, enable, 1'b0, dir, 1'b0};
            3'd1:    rdata = {29'd0, aborted, done, busy};
            3'd2:    rdata = {16'd0, steps};
            3'd3:    rdata = period;
            3'd4:    rdata = pos;
            default: rdata = '0;
        endcase
    end

    // Bus handshake: single-cycle ack, read data registered alongside it.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_ack_o <= 1'b0;
            wb_dat_o <= '0;
        end else begin
            wb_ack_o <= req;
            if (req) begin
                wb_dat_o <= rdata;
            end
        end
    end

    // Configuration and status registers; a DONE/ABORTED set beats a same-cycle clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            dir     <= 1'b0;
            enable  <= 1'b0;
            irq_en  <= 1'b0;
            steps   <= '0;
            period  <= '0;
            done    <= 1'b0;
            aborted <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                dir    <= wb_dat_i[1];
                enable <= wb_dat_i[3];
                irq_en <= wb_dat_i[4];
            end
            if (wr && (idx == 3'd2)) steps  <= wb_dat_i[15:0];
            if (wr && (idx == 3'd3)) period <= wb_dat_i;
            if (wr_status && wb_dat_i[1]) done    <= 1'b0;
            if (wr_status && wb_dat_i[2]) aborted <= 1'b0;
            if (done_set) done    <= 1'b1;
            if (kill)     aborted <= 1'b1;
        end
    end

    // Move sequencer: IDLE -> SETUP -> (HIGH -> LOW)*, position updated on each rise.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            remaining <= '0;
            pos       <= '0;
            step_o    <= 1'b0;
            dir_o     <= 1'b0;
        end else begin
            if (wr && (idx == 3'd4) && !busy) begin
                pos <= signed'(wb_dat_i);
            end
            if (kill) begin
                state  <= S_IDLE;
                step_o <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start_ok) begin
                            dir_o     <= wb_dat_i[1];
                            remaining <= steps;
                            if (steps != 16'd0) begin
                                state <= S_SETUP;
                                cnt   <= SETUP_CNT;
                            end
                        end
                    end
                    S_SETUP: begin
                        if (cnt == 32'd0) begin
                            state     <= S_HIGH;
                            step_o    <= 1'b1;
                            cnt       <= HIGH_CNT;
                            pos       <= dir_o ? pos + 32'sd1 : pos - 32'sd1;
                            remaining <= remaining - 16'd1;
                        end else begin
                            cnt <= cnt - 32'd1;
                        end
                    end
                    S_HIGH: begin
                        if (cnt == 32'd0) begin
                            state  <= S_LOW;
                            step_o <= 1'b0;
                            cnt    <= low_cycles(period);
                        end else begin
                            cnt <= cnt - 32'd1;
                        end
                    end
                    S_LOW: begin
                        if (cnt == 32'd0) begin
                            if (remaining != 16'd0) begin
                                state     <= S_HIGH;
                                step_o    <= 1'b1;
                                cnt       <= HIGH_CNT;
                                pos       <= dir_o ? pos + 32'sd1 : pos - 32'sd1;
                                remaining <= remaining - 16'd1;
                            end else begin
                                state <= S_IDLE;
                            end
                        end else begin
                            cnt <= cnt - 32'd1;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_wb_stepper.sv
// tb_wb_stepper: directed self-checking bench for wb_stepper.
module tb_wb_stepper;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] adr = '0;
    logic [31:0] dat_i = '0;
    logic [31:0] dat_o;
    logic [3:0]  sel = 4'hF;
    logic        we = 1'b0;
    logic        cyc = 1'b0;
    logic        stb = 1'b0;
    logic        ack;
    logic        step;
    logic        dir;
    logic        en_n;
    logic        intr;

    int checks = 0;
    int errors = 0;
    int cyc_cnt = 0;
    int ack_cyc = 0;
    int rises[$];
    int falls[$];
    logic prev_step = 1'b0;

    wb_stepper #(.PULSE_W(10), .DIR_SETUP(50)) dut (
        .clk(clk), .rst(rst),
        .wb_adr_i(adr), .wb_dat_i(dat_i), .wb_dat_o(dat_o), .wb_sel_i(sel),
        .wb_we_i(we), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_ack_o(ack),
        .step_o(step), .dir_o(dir), .en_n_o(en_n), .intr(intr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Record the cycle index of every STEP rise and fall.
    always @(negedge clk) begin
        if (step === 1'b1 && prev_step === 1'b0) rises.push_back(cyc_cnt);
        if (step === 1'b0 && prev_step === 1'b1) falls.push_back(cyc_cnt);
        prev_step = step;
    end

    task automatic wb_write(input logic [2:0] idx, input logic [31:0] data);
        int k;
        @(negedge clk);
        adr = {27'd0, idx, 2'b00}; dat_i = data; we = 1'b1; cyc = 1'b1; stb = 1'b1;
        k = 0;
        do begin @(posedge clk); #1; k++; end while (!ack && k < 16);
        ack_cyc = cyc_cnt;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        checks++;
        if (ack !== 1'b1) begin errors++; $display("FAIL wr_ack idx=%0d: ack=%b required 1", idx, ack); end
    endtask

    task automatic wb_read(input logic [2:0] idx, output logic [31:0] data);
        int k;
        @(negedge clk);
        adr = {27'd0, idx, 2'b00}; we = 1'b0; cyc = 1'b1; stb = 1'b1;
        k = 0;
        do begin @(posedge clk); #1; k++; end while (!ack && k < 16);
        data = dat_o;
        cyc = 1'b0; stb = 1'b0;
        checks++;
        if (ack !== 1'b1) begin errors++; $display("FAIL rd_ack idx=%0d: ack=%b required 1", idx, ack); end
    endtask

    task automatic wait_idle();
        logic [31:0] s;
        int k;
        k = 0;
        do begin wb_read(3'd1, s); k++; end while (s[0] !== 1'b0 && k < 2000);
        checks++;
        if (s[0] !== 1'b0) begin errors++; $display("FAIL wait_idle: busy=%b required 0", s[0]); end
    endtask

    task automatic wait_rises(input int n);
        int k;
        k = 0;
        while (rises.size() < n && k < 5000) begin @(negedge clk); k++; end
        checks++;
        if (rises.size() < n) begin errors++; $display("FAIL wait_rises: got %0d required %0d", rises.size(), n); end
    endtask

    task automatic test_reset();
        logic [31:0] r;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (step !== 1'b0) begin errors++; $display("FAIL rst_step: %b required 0", step); end
        checks++; if (dir !== 1'b0) begin errors++; $display("FAIL rst_dir: %b required 0", dir); end
        checks++; if (en_n !== 1'b1) begin errors++; $display("FAIL rst_en_n: %b required 1", en_n); end
        checks++; if (intr !== 1'b0) begin errors++; $display("FAIL rst_intr: %b required 0", intr); end
        checks++; if (ack !== 1'b0) begin errors++; $display("FAIL rst_ack: %b required 0", ack); end
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            wb_read(3'(i), r);
            checks++;
            if (r !== 32'd0) begin errors++; $display("FAIL rst_reg%0d: %h required 0", i, r); end
        end
        rises.delete(); falls.delete();
    endtask

    task automatic test_forward_move();
        logic [31:0] r;
        int a;
        wb_write(3'd2, 32'd4);
        wb_write(3'd3, 32'd40);
        rises.delete(); falls.delete();
        wb_write(3'd0, 32'h0B);
        a = ack_cyc;
        wait_idle();
        checks++; if (rises.size() !== 4) begin errors++; $display("FAIL fwd_count: %0d pulses required 4", rises.size()); end
        if (rises.size() == 4 && falls.size() == 4) begin
            checks++; if (rises[0] - a !== 50) begin errors++; $display("FAIL fwd_setup: %0d required 50", rises[0] - a); end
            for (int i = 0; i < 4; i++) begin
                checks++; if (falls[i] - rises[i] !== 10) begin errors++; $display("FAIL fwd_width%0d: %0d required 10", i, falls[i] - rises[i]); end
                if (i > 0) begin
                    checks++; if (rises[i] - rises[i-1] !== 40) begin errors++; $display("FAIL fwd_period%0d: %0d required 40", i, rises[i] - rises[i-1]); end
                end
            end
        end
        checks++; if (dir !== 1'b1) begin errors++; $display("FAIL fwd_dir: %b required 1", dir); end
        checks++; if (en_n !== 1'b0) begin errors++; $display("FAIL fwd_en_n: %b required 0", en_n); end
        wb_read(3'd4, r);
        checks++; if (r !== 32'd4) begin errors++; $display("FAIL fwd_pos: %h required 4", r); end
        wb_read(3'd1, r);
        checks++; if (r !== 32'h2) begin errors++; $display("FAIL fwd_status: %h required 2", r); end
    endtask

    task automatic test_reverse_clamp_irq();
        logic [31:0] r;
        wb_write(3'd1, 32'h2);
        wb_write(3'd2, 32'd3);
        wb_write(3'd3, 32'd5);
        rises.delete(); falls.delete();
        wb_write(3'd0, 32'h19);
        wait_idle();
        checks++; if (rises.size() !== 3) begin errors++; $display("FAIL rev_count: %0d pulses required 3", rises.size()); end
        if (rises.size() == 3 && falls.size() == 3) begin
            for (int i = 1; i < 3; i++) begin
                checks++; if (rises[i] - rises[i-1] !== 11) begin errors++; $display("FAIL rev_period%0d: %0d required 11", i, rises[i] - rises[i-1]); end
            end
            checks++; if (falls[2] - rises[2] !== 10) begin errors++; $display("FAIL rev_width: %0d required 10", falls[2] - rises[2]); end
        end
        checks++; if (dir !== 1'b0) begin errors++; $display("FAIL rev_dir: %b required 0", dir); end
        wb_read(3'd4, r);
        checks++; if (r !== 32'd1) begin errors++; $display("FAIL rev_pos: %h required 1", r); end
        wb_read(3'd0, r);
        checks++; if (r !== 32'h18) begin errors++; $display("FAIL rev_ctrl: %h required 18", r); end
        checks++; if (intr !== 1'b1) begin errors++; $display("FAIL rev_intr_set: %b required 1", intr); end
        wb_write(3'd1, 32'h2);
        checks++; if (intr !== 1'b0) begin errors++; $display("FAIL rev_intr_clr: %b required 0", intr); end
    endtask

    task automatic test_abort();
        logic [31:0] r;
        wb_write(3'd0, 32'h08);
        wb_write(3'd4, 32'd0);
        wb_write(3'd2, 32'd100);
        wb_write(3'd3, 32'd20);
        rises.delete(); falls.delete();
        wb_write(3'd0, 32'h0B);
        wait_rises(3);
        wb_write(3'd0, 32'h0B);
        wb_read(3'd1, r);
        checks++; if (r !== 32'h1) begin errors++; $display("FAIL abort_busy: %h required 1", r); end
        wait_rises(7);
        if (rises.size() >= 4) begin
            checks++; if (rises[3] - rises[2] !== 20) begin errors++; $display("FAIL abort_restart_ignored: %0d required 20", rises[3] - rises[2]); end
        end
        checks++; if (step !== 1'b1) begin errors++; $display("FAIL abort_pre_step: %b required 1", step); end
        wb_write(3'd0, 32'h0E);
        checks++; if (step !== 1'b0) begin errors++; $display("FAIL abort_step_drop: %b required 0", step); end
        repeat (60) @(negedge clk);
        checks++; if (rises.size() !== 7) begin errors++; $display("FAIL abort_no_more: %0d pulses required 7", rises.size()); end
        wb_read(3'd4, r);
        checks++; if (r !== 32'd7) begin errors++; $display("FAIL abort_pos: %h required 7", r); end
        wb_read(3'd1, r);
        checks++; if (r !== 32'h6) begin errors++; $display("FAIL abort_status: %h required 6", r); end
    endtask

    task automatic test_zero_steps_and_disabled();
        logic [31:0] r;
        wb_write(3'd1, 32'h6);
        wb_write(3'd2, 32'd0);
        rises.delete(); falls.delete();
        wb_write(3'd0, 32'h19);
        checks++; if (intr !== 1'b1) begin errors++; $display("FAIL zero_done_on_ack: intr=%b required 1", intr); end
        wb_read(3'd1, r);
        checks++; if (r !== 32'h2) begin errors++; $display("FAIL zero_status: %h required 2", r); end
        wb_write(3'd1, 32'h2);
        wb_write(3'd2, 32'd5);
        wb_write(3'd0, 32'h01);
        checks++; if (en_n !== 1'b1) begin errors++; $display("FAIL dis_en_n: %b required 1", en_n); end
        wb_read(3'd1, r);
        checks++; if (r !== 32'h0) begin errors++; $display("FAIL dis_status: %h required 0", r); end
        repeat (80) @(negedge clk);
        checks++; if (rises.size() !== 0) begin errors++; $display("FAIL zero_no_pulse: %0d pulses required 0", rises.size()); end
    endtask

    task automatic test_pos_wrap_and_regs();
        logic [31:0] r;
        wb_write(3'd0, 32'h08);
        wb_write(3'd4, 32'h7FFF_FFFF);
        wb_write(3'd2, 32'd1);
        wb_write(3'd3, 32'd20);
        wb_write(3'd0, 32'h0B);
        wait_idle();
        wb_read(3'd4, r);
        checks++; if (r !== 32'h8000_0000) begin errors++; $display("FAIL wrap_pos: %h required 80000000", r); end
        wb_write(3'd2, 32'd2);
        wb_write(3'd0, 32'h0B);
        wb_write(3'd4, 32'h0000_1234);
        wait_idle();
        wb_read(3'd4, r);
        checks++; if (r !== 32'h8000_0002) begin errors++; $display("FAIL busy_pos_write: %h required 80000002", r); end
        wb_write(3'd2, 32'hABCD_1234);
        wb_read(3'd2, r);
        checks++; if (r !== 32'h0000_1234) begin errors++; $display("FAIL steps_mask: %h required 1234", r); end
        for (int i = 5; i < 8; i++) begin
            wb_write(3'(i), 32'hFFFF_FFFF);
            wb_read(3'(i), r);
            checks++; if (r !== 32'd0) begin errors++; $display("FAIL unused_reg%0d: %h required 0", i, r); end
        end
    endtask

    task automatic test_reset_mid_move();
        logic [31:0] r;
        wb_write(3'd2, 32'd10);
        rises.delete(); falls.delete();
        wb_write(3'd0, 32'h0B);
        wait_rises(2);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        checks++; if (step !== 1'b0) begin errors++; $display("FAIL midrst_step: %b required 0", step); end
        checks++; if (en_n !== 1'b1) begin errors++; $display("FAIL midrst_en_n: %b required 1", en_n); end
        checks++; if (dir !== 1'b0) begin errors++; $display("FAIL midrst_dir: %b required 0", dir); end
        rst = 1'b0;
        wb_read(3'd4, r);
        checks++; if (r !== 32'd0) begin errors++; $display("FAIL midrst_pos: %h required 0", r); end
        wb_read(3'd1, r);
        checks++; if (r !== 32'd0) begin errors++; $display("FAIL midrst_status: %h required 0", r); end
    endtask

    initial begin
        test_reset();
        test_forward_move();
        test_reverse_clamp_irq();
        test_abort();
        test_zero_steps_and_disabled();
        test_pos_wrap_and_regs();
        test_reset_mid_move();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
